regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 65 ++++++
 tb/tb_regfile_sb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-ported register file with a one-bit-per-register issue scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy state to the read ports.
module regfile_sb #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRP   = 2,
    parameter  int NWP   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NWP-1:0]            we_i,
    input  logic [NWP-1:0][AW-1:0]    wr_addr_i,
    input  logic [NWP-1:0][XLEN-1:0]  wr_d_i,
    input  logic                      iss_valid_i,
    input  logic [AW-1:0]             iss_rd_i,
    input  logic [NRP-1:0][AW-1:0]    rd_addr_i,
    output logic [NRP-1:0][XLEN-1:0]  rd_d_o,
    output logic [NRP-1:0]            rd_busy_o,
    output logic [NREGS-1:0]          busy_o
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    // Later ports overwrite earlier ones, and the issue comes last so it wins over a write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int w = 0; w < NWP; w++) begin
                if (we_i[w] && (wr_addr_i[w] != '0)) begin
                    regs[wr_addr_i[w]] <= wr_d_i[w];
                    busy[wr_addr_i[w]] <= 1'b0;
                end
            end
            if (iss_valid_i && (iss_rd_i != '0)) begin
                busy[iss_rd_i] <= 1'b1;
            end
        end
    end

    assign busy_o = busy;

    always_comb begin
        for (int p = 0; p < NRP; p++) begin
            rd_d_o[p]    = regs[rd_addr_i[p]];
            rd_busy_o[p] = busy[rd_addr_i[p]];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed during reset so reads stay at zero.
            for (int w = 0; w < NWP; w++) begin
                if (rst_n_i && we_i[w] && (wr_addr_i[w] != '0) &&
                    (wr_addr_i[w] == rd_addr_i[p])) begin
                    rd_d_o[p]    = wr_d_i[w];
                    rd_busy_o[p] = iss_valid_i && (iss_rd_i == rd_addr_i[p]);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb: reset, write priority, scoreboard set/clear and async reset.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRP   = 2;
    localparam int NWP   = 2;
    localparam int AW    = 5;

    logic                     clk;
    logic                     rst_n;
    logic [NWP-1:0]           we;
    logic [NWP-1:0][AW-1:0]   wr_addr;
    logic [NWP-1:0][XLEN-1:0] wr_d;
    logic                     iss_valid;
    logic [AW-1:0]            iss_rd;
    logic [NRP-1:0][AW-1:0]   rd_addr;
    logic [NRP-1:0][XLEN-1:0] rd_d;
    logic [NRP-1:0]           rd_busy;
    logic [NREGS-1:0]         busy;

    int testsRun = 0;
    int testsFailed = 0;

    regfile_sb #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .NRP  (NRP),
        .NWP  (NWP)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .we_i       (we),
        .wr_addr_i  (wr_addr),
        .wr_d_i     (wr_d),
        .iss_valid_i(iss_valid),
        .iss_rd_i   (iss_rd),
        .rd_addr_i  (rd_addr),
        .rd_d_o     (rd_d),
        .rd_busy_o  (rd_busy),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] weV,
                                 input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                                 input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                                 input logic issV, input logic [AW-1:0] issA);
        we         = weV;
        wr_addr[0] = a0;
        wr_d[0]    = d0;
        wr_addr[1] = a1;
        wr_d[1]    = d1;
        iss_valid  = issV;
        iss_rd     = issA;
    endtask

    task automatic idle();
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic readPorts(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr[0] = a0;
        rd_addr[1] = a1;
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_addr = '0;
        // A write and an issue presented during reset must be discarded.
        applyStimulus(2'b01, 5'd6, 32'h0000_0077, '0, '0, 1'b1, 5'd6);
        #12;
        checkOutput("reset_busy_vec", busy, '0);
        for (int a = 0; a < NREGS; a++) begin
            readPorts(AW'(a), AW'(NREGS - 1 - a));
            checkOutput($sformatf("reset_rd0_x%0d", a), rd_d[0], '0);
            checkOutput($sformatf("reset_rd1_x%0d", NREGS - 1 - a), rd_d[1], '0);
            checkOutput($sformatf("reset_busy0_x%0d", a), {31'b0, rd_busy[0]}, '0);
            checkOutput($sformatf("reset_busy1_x%0d", NREGS - 1 - a), {31'b0, rd_busy[1]}, '0);
        end
        waitEdge();
        idle();
        rst_n = 1'b1;
        readPorts(5'd6, 5'd6);
        checkOutput("reset_discard_x6", rd_d[0], '0);
        checkOutput("reset_discard_busy", busy, '0);

        applyStimulus(2'b01, 5'd5, 32'hDEAD_BEEF, '0, '0, 1'b0, '0);
        waitEdge();
        idle();
        readPorts(5'd5, 5'd5);
        checkOutput("wr_x5_port0", rd_d[0], 32'hDEAD_BEEF);
        checkOutput("wr_x5_port1", rd_d[1], 32'hDEAD_BEEF);

        applyStimulus(2'b01, 5'd0, 32'h0000_1234, '0, '0, 1'b0, '0);
        waitEdge();
        idle();
        readPorts(5'd0, 5'd5);
        checkOutput("wr_x0_ignored", rd_d[0], '0);
        checkOutput("x5_kept", rd_d[1], 32'hDEAD_BEEF);

        applyStimulus(2'b11, 5'd7, 32'h0000_0011, 5'd7, 32'h0000_0022, 1'b0, '0);
        waitEdge();
        idle();
        readPorts(5'd7, 5'd7);
        checkOutput("x7_port1_wins", rd_d[0], 32'h0000_0022);

        applyStimulus(2'b11, 5'd10, 32'h1010_1010, 5'd11, 32'h1111_1111, 1'b0, '0);
        waitEdge();
        idle();
        readPorts(5'd10, 5'd11);
        checkOutput("dual_wr_x10", rd_d[0], 32'h1010_1010);
        checkOutput("dual_wr_x11", rd_d[1], 32'h1111_1111);

        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1, 5'd3);
        waitEdge();
        idle();
        readPorts(5'd3, 5'd2);
        checkOutput("iss_x3_busy_vec", busy, 32'h0000_0008);
        checkOutput("iss_x3_rd_busy", {31'b0, rd_busy[0]}, 32'd1);
        checkOutput("x2_not_busy", {31'b0, rd_busy[1]}, 32'd0);

        applyStimulus(2'b01, 5'd3, 32'h0000_0055, '0, '0, 1'b1, 5'd3);
        waitEdge();
        idle();
        readPorts(5'd3, 5'd3);
        checkOutput("iss_wins_busy", busy, 32'h0000_0008);
        checkOutput("iss_wins_data", rd_d[1], 32'h0000_0055);

        applyStimulus(2'b10, '0, '0, 5'd3, 32'h0000_0056, 1'b0, '0);
        waitEdge();
        idle();
        readPorts(5'd3, 5'd3);
        checkOutput("wr_clears_busy", busy, '0);
        checkOutput("wr_x3_again", rd_d[0], 32'h0000_0056);

        applyStimulus(2'b01, 5'd12, 32'h0C0C_0C0C, '0, '0, 1'b1, 5'd0);
        waitEdge();
        idle();
        readPorts(5'd12, 5'd0);
        checkOutput("wr_nonbusy_data", rd_d[0], 32'h0C0C_0C0C);
        checkOutput("wr_nonbusy_iss_x0", busy, '0);

        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1, 5'd8);
        waitEdge();
        waitEdge();
        idle();
        checkOutput("iss_twice_busy", busy, 32'h0000_0100);
        applyStimulus(2'b10, '0, '0, 5'd8, 32'h0000_0088, 1'b0, '0);
        waitEdge();
        idle();
        checkOutput("iss_twice_single_clear", busy, '0);

        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1, 5'd13);
        waitEdge();
        idle();
        // Reads are sampled while the write is still pending, before the edge.
        applyStimulus(2'b11, 5'd13, 32'h1313_1313, 5'd9, 32'hA5A5_A5A5, 1'b0, '0);
        readPorts(5'd9, 5'd13);
`ifdef REGFILE_BYPASS_EN
        checkOutput("same_cycle_x9", rd_d[0], 32'hA5A5_A5A5);
        checkOutput("same_cycle_x13_busy", {31'b0, rd_busy[1]}, 32'd0);
        checkOutput("same_cycle_x13_data", rd_d[1], 32'h1313_1313);
`else
        checkOutput("same_cycle_x9", rd_d[0], '0);
        checkOutput("same_cycle_x13_busy", {31'b0, rd_busy[1]}, 32'd1);
        checkOutput("same_cycle_x13_data", rd_d[1], '0);
`endif
        checkOutput("same_cycle_busy_vec", busy, 32'h0000_2000);
        waitEdge();
        idle();
        readPorts(5'd9, 5'd13);
        checkOutput("after_edge_x9", rd_d[0], 32'hA5A5_A5A5);
        checkOutput("after_edge_x13_busy", busy, '0);

        applyStimulus(2'b01, 5'd4, 32'h0000_0044, '0, '0, 1'b1, 5'd4);
        waitEdge();
        idle();
        readPorts(5'd4, 5'd5);
        checkOutput("x4_busy_before_rst", busy, 32'h0000_0010);
        #2;
        rst_n = 1'b0;
        applyStimulus(2'b01, 5'd4, 32'hFFFF_FFFF, '0, '0, 1'b1, 5'd4);
        #1;
        checkOutput("async_rst_busy_vec", busy, '0);
        checkOutput("async_rst_x4_data", rd_d[0], '0);
        checkOutput("async_rst_x4_busy", {31'b0, rd_busy[0]}, '0);
        checkOutput("async_rst_x5_data", rd_d[1], '0);
        waitEdge();
        checkOutput("rst_held_busy_vec", busy, '0);
        checkOutput("rst_held_x4_data", rd_d[0], '0);
        idle();
        rst_n = 1'b1;
        waitEdge();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
